// File: rtl/vm_coin_sched.sv
// Coin front-end for the vending-machine core: two acceptor FIFOs, round-robin
// issue with an idle gap, a settle hold after core events, and sale/change counters.
module vm_coin_sched #(
    parameter int DEPTH         = 2,
    parameter int GAP_CYCLES    = 1,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             A_valid,
    input  logic [1:0]       A_coin,
    output logic             A_ready,
    input  logic             B_valid,
    input  logic [1:0]       B_coin,
    output logic             B_ready,
    output logic [1:0]       Core_D_in,
    input  logic             Core_D_out,
    input  logic             Core_D_C,
    output logic             Busy,
    output logic [CNT_W-1:0] Sale_cnt,
    output logic [CNT_W-1:0] Change_cnt,
    output logic             Err_illegal
);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = $clog2(DEPTH) + 1;
    localparam int TMAX = (GAP_CYCLES > SETTLE_CYCLES) ? GAP_CYCLES : SETTLE_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [CW-1:0] FULL        = CW'(DEPTH);
    localparam logic [TW-1:0] GAP_LAST    = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP, SETTLE} state_t;

    // Slot 0 is acceptor A, slot 1 is acceptor B.
    logic [1:0]       r_mem   [2][DEPTH];
    logic [AW-1:0]    r_wrPtr [2];
    logic [AW-1:0]    r_rdPtr [2];
    logic [CW-1:0]    r_count [2];
    logic [1:0]       w_coin  [2];
    logic [1:0]       w_valid;
    logic [1:0]       w_ready;
    logic [1:0]       w_legal;
    logic [1:0]       w_push;
    logic [1:0]       w_pop;
    logic [1:0]       w_notEmpty;

    state_t           r_state;
    state_t           w_nextState;
    logic [TW-1:0]    r_timer;
    logic             r_rrPtr;
    logic             r_evtSeen;
    logic             w_evt;
    logic             w_anyPending;
    logic             w_selB;
    logic [1:0]       r_coreDIn;
    logic [1:0]       w_issueCoin;
    logic             r_dOutQ;
    logic             r_dcQ;
    logic             r_errIllegal;
    logic [CNT_W-1:0] r_saleCnt;
    logic [CNT_W-1:0] r_changeCnt;

    always_comb begin
        w_coin[0] = A_coin;
        w_coin[1] = B_coin;
        w_valid   = {B_valid, A_valid};
        for (int s = 0; s < 2; s++) begin
            w_ready[s]    = r_count[s] < FULL;
            w_notEmpty[s] = r_count[s] != '0;
            w_legal[s]    = (w_coin[s] == 2'b01) || (w_coin[s] == 2'b10);
            w_push[s]     = w_valid[s] && w_ready[s] && w_legal[s];
        end
    end

    assign w_anyPending = |w_notEmpty;
    assign w_evt        = Core_D_out || Core_D_C;

    always_ff @(posedge Clk) begin
        for (int s = 0; s < 2; s++) begin
            if (Reset) begin
                r_wrPtr[s] <= '0;
                r_rdPtr[s] <= '0;
                r_count[s] <= '0;
            end else begin
                if (w_push[s]) r_wrPtr[s] <= r_wrPtr[s] + 1'b1;
                if (w_pop[s])  r_rdPtr[s] <= r_rdPtr[s] + 1'b1;
                if (w_push[s] && !w_pop[s])
                    r_count[s] <= r_count[s] + 1'b1;
                else if (!w_push[s] && w_pop[s])
                    r_count[s] <= r_count[s] - 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        for (int s = 0; s < 2; s++) begin
            if (w_push[s]) r_mem[s][r_wrPtr[s]] <= w_coin[s];
        end
    end

    // Timer counts cycles spent in the current state; it restarts on every transition.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state != w_nextState || r_state == IDLE)
                r_timer <= '0;
            else
                r_timer <= r_timer + 1'b1;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_anyPending) w_nextState = ISSUE;
            ISSUE:   w_nextState = GAP;
            GAP: begin
                if (r_timer == GAP_LAST) begin
                    if (r_evtSeen || w_evt) w_nextState = SETTLE;
                    else if (w_anyPending)  w_nextState = ISSUE;
                    else                    w_nextState = IDLE;
                end
            end
            SETTLE: begin
                if (r_timer == SETTLE_LAST)
                    w_nextState = w_anyPending ? ISSUE : IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        Busy   = (r_state != IDLE);
        w_selB = (w_notEmpty[0] && w_notEmpty[1]) ? r_rrPtr : w_notEmpty[1];
        w_pop[0] = (r_state == ISSUE) && w_notEmpty[0] && !w_selB;
        w_pop[1] = (r_state == ISSUE) && w_notEmpty[1] && w_selB;
        if (w_pop[0])      w_issueCoin = r_mem[0][r_rdPtr[0]];
        else if (w_pop[1]) w_issueCoin = r_mem[1][r_rdPtr[1]];
        else               w_issueCoin = 2'b00;
    end

    // An event seen in the issue cycle or any gap cycle forces a settle window.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_coreDIn <= 2'b00;
            r_rrPtr   <= 1'b0;
            r_evtSeen <= 1'b0;
        end else begin
            r_coreDIn <= w_issueCoin;
            if (w_pop[0])      r_rrPtr <= 1'b1;
            else if (w_pop[1]) r_rrPtr <= 1'b0;
            case (r_state)
                ISSUE:   r_evtSeen <= w_evt;
                GAP:     r_evtSeen <= r_evtSeen || w_evt;
                default: r_evtSeen <= 1'b0;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_dOutQ      <= 1'b0;
            r_dcQ        <= 1'b0;
            r_saleCnt    <= '0;
            r_changeCnt  <= '0;
            r_errIllegal <= 1'b0;
        end else begin
            r_dOutQ <= Core_D_out;
            r_dcQ   <= Core_D_C;
            if (Core_D_out && !r_dOutQ && r_saleCnt != '1)
                r_saleCnt <= r_saleCnt + 1'b1;
            if (Core_D_C && !r_dcQ && r_changeCnt != '1)
                r_changeCnt <= r_changeCnt + 1'b1;
            r_errIllegal <= |(w_valid & w_ready & ~w_legal);
        end
    end

    assign A_ready     = w_ready[0];
    assign B_ready     = w_ready[1];
    assign Core_D_in   = r_coreDIn;
    assign Sale_cnt    = r_saleCnt;
    assign Change_cnt  = r_changeCnt;
    assign Err_illegal = r_errIllegal;

endmodule

// File: tb/tb_vm_coin_sched.sv
// Self-checking bench for vm_coin_sched: expected coins go into a queue when offered
// and are popped when the core input shows a coin.
module tb_vm_coin_sched;
    localparam int CNT_W = 8;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic             A_valid = 1'b0;
    logic [1:0]       A_coin = 2'b00;
    logic             A_ready;
    logic             B_valid = 1'b0;
    logic [1:0]       B_coin = 2'b00;
    logic             B_ready;
    logic [1:0]       Core_D_in;
    logic             Core_D_out = 1'b0;
    logic             Core_D_C = 1'b0;
    logic             Busy;
    logic [CNT_W-1:0] Sale_cnt;
    logic [CNT_W-1:0] Change_cnt;
    logic             Err_illegal;

    int         vecCount = 0;
    int         missCount = 0;
    logic [1:0] expQ[$];
    logic [1:0] expCoin;

    vm_coin_sched #(.DEPTH(2), .GAP_CYCLES(1), .SETTLE_CYCLES(4), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset),
        .A_valid(A_valid), .A_coin(A_coin), .A_ready(A_ready),
        .B_valid(B_valid), .B_coin(B_coin), .B_ready(B_ready),
        .Core_D_in(Core_D_in), .Core_D_out(Core_D_out), .Core_D_C(Core_D_C),
        .Busy(Busy), .Sale_cnt(Sale_cnt), .Change_cnt(Change_cnt),
        .Err_illegal(Err_illegal)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic doReset;
        A_valid = 1'b0; B_valid = 1'b0; Core_D_out = 1'b0; Core_D_C = 1'b0;
        Reset = 1'b1;
        tick;
        Reset = 1'b0;
        expQ.delete();
    endtask

    // An empty queue yields 11, a code the DUT can never issue.
    function automatic logic [1:0] popExp();
        if (expQ.size() == 0) return 2'b11;
        return expQ.pop_front();
    endfunction

    task automatic test_reset;
        doReset;
        for (int i = 0; i < 10; i++) begin
            vecCount++;
            if ({A_ready, B_ready, Core_D_in, Busy, Err_illegal} !== 6'b110000 ||
                Sale_cnt !== 8'd0 || Change_cnt !== 8'd0) begin
                missCount++;
                $display("[TB] FAIL reset_idle cyc%0d: rdy=%b%b din=%b busy=%b err=%b sale=%0d chg=%0d, want rdy=11 din=00 busy=0 err=0 cnt=0",
                         i, A_ready, B_ready, Core_D_in, Busy, Err_illegal, Sale_cnt, Change_cnt);
            end
            tick;
        end
    endtask

    task automatic test_stream;
        doReset;
        A_valid = 1'b1; A_coin = 2'b01; expQ.push_back(2'b01);
        tick;
        A_coin = 2'b10; expQ.push_back(2'b10);
        tick;
        A_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            expCoin = (i % 2 == 0) ? popExp() : 2'b00;
            vecCount++;
            if (Core_D_in !== expCoin) begin
                missCount++;
                $display("[TB] FAIL stream cyc%0d: din=%b want %b", i, Core_D_in, expCoin);
            end
        end
        vecCount++;
        if (Busy !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL stream_busy_drop: busy=%b want 0", Busy);
        end
    endtask

    task automatic test_round_robin;
        doReset;
        A_valid = 1'b1; A_coin = 2'b01; B_valid = 1'b1; B_coin = 2'b10;
        expQ.push_back(2'b01); expQ.push_back(2'b10);
        tick;
        expQ.push_back(2'b01); expQ.push_back(2'b10);
        tick;
        A_valid = 1'b0; B_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick;
            expCoin = (i % 2 == 0) ? popExp() : 2'b00;
            vecCount++;
            if (Core_D_in !== expCoin) begin
                missCount++;
                $display("[TB] FAIL rr_order cyc%0d: din=%b want %b", i, Core_D_in, expCoin);
            end
        end
        vecCount++;
        if (Busy !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL rr_idle: busy=%b want 0", Busy);
        end
    endtask

    task automatic test_settle_full;
        doReset;
        B_valid = 1'b1; B_coin = 2'b10; expQ.push_back(2'b10);
        tick;
        B_valid = 1'b0;
        tick;
        tick;
        expCoin = popExp();
        vecCount++;
        if (Core_D_in !== expCoin) begin
            missCount++;
            $display("[TB] FAIL settle_first_coin: din=%b want %b", Core_D_in, expCoin);
        end
        // Dispense pulse during the gap while A starts filling.
        Core_D_out = 1'b1;
        A_valid = 1'b1; A_coin = 2'b01; expQ.push_back(2'b01);
        tick;
        Core_D_out = 1'b0;
        vecCount++;
        if (Sale_cnt !== 8'd1 || Core_D_in !== 2'b00) begin
            missCount++;
            $display("[TB] FAIL settle_sale: sale=%0d din=%b want sale=1 din=00", Sale_cnt, Core_D_in);
        end
        expQ.push_back(2'b01);
        tick;
        vecCount++;
        if (A_ready !== 1'b0 || Core_D_in !== 2'b00) begin
            missCount++;
            $display("[TB] FAIL full_ready: A_ready=%b din=%b want 0 and 00", A_ready, Core_D_in);
        end
        A_coin = 2'b10;
        tick;
        A_valid = 1'b0;
        vecCount++;
        if (A_ready !== 1'b0 || Busy !== 1'b1 || Core_D_in !== 2'b00) begin
            missCount++;
            $display("[TB] FAIL full_hold: A_ready=%b busy=%b din=%b want 0 1 00", A_ready, Busy, Core_D_in);
        end
        // Remaining settle cycle plus the issue cycle before the queued coin appears.
        for (int i = 0; i < 2; i++) begin
            tick;
            vecCount++;
            if (Core_D_in !== 2'b00 || A_ready !== 1'b0) begin
                missCount++;
                $display("[TB] FAIL settle_quiet cyc%0d: din=%b A_ready=%b want 00 0", i, Core_D_in, A_ready);
            end
        end
        tick;
        expCoin = popExp();
        vecCount++;
        if (Core_D_in !== expCoin || A_ready !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL settle_release: din=%b A_ready=%b want %b 1", Core_D_in, A_ready, expCoin);
        end
        tick;
        tick;
        expCoin = popExp();
        vecCount++;
        if (Core_D_in !== expCoin) begin
            missCount++;
            $display("[TB] FAIL settle_second: din=%b want %b", Core_D_in, expCoin);
        end
        tick;
        vecCount++;
        if (Busy !== 1'b0 || Core_D_in !== 2'b00 || expQ.size() != 0) begin
            missCount++;
            $display("[TB] FAIL third_rejected: busy=%b din=%b left=%0d want 0 00 0", Busy, Core_D_in, expQ.size());
        end
    endtask

    task automatic test_events;
        doReset;
        Core_D_out = 1'b1; Core_D_C = 1'b1;
        tick;
        vecCount++;
        if (Sale_cnt !== 8'd1 || Change_cnt !== 8'd1) begin
            missCount++;
            $display("[TB] FAIL simul_edges: sale=%0d chg=%0d want 1 1", Sale_cnt, Change_cnt);
        end
        tick;
        tick;
        vecCount++;
        if (Sale_cnt !== 8'd1 || Change_cnt !== 8'd1) begin
            missCount++;
            $display("[TB] FAIL level_hold: sale=%0d chg=%0d want 1 1", Sale_cnt, Change_cnt);
        end
        Core_D_out = 1'b0; Core_D_C = 1'b0;
        tick;
        Core_D_C = 1'b1;
        tick;
        Core_D_C = 1'b0;
        vecCount++;
        if (Sale_cnt !== 8'd1 || Change_cnt !== 8'd2) begin
            missCount++;
            $display("[TB] FAIL change_only: sale=%0d chg=%0d want 1 2", Sale_cnt, Change_cnt);
        end
        for (int i = 0; i < 300; i++) begin
            Core_D_out = 1'b1;
            tick;
            Core_D_out = 1'b0;
            tick;
        end
        vecCount++;
        if (Sale_cnt !== 8'hFF || Change_cnt !== 8'd2) begin
            missCount++;
            $display("[TB] FAIL saturate: sale=%0d chg=%0d want 255 2", Sale_cnt, Change_cnt);
        end
    endtask

    task automatic test_illegal;
        doReset;
        A_valid = 1'b1; A_coin = 2'b11;
        tick;
        A_valid = 1'b0;
        vecCount++;
        if (Err_illegal !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL illegal_pulse: err=%b want 1", Err_illegal);
        end
        tick;
        vecCount++;
        if (Err_illegal !== 1'b0 || Busy !== 1'b0 || Core_D_in !== 2'b00) begin
            missCount++;
            $display("[TB] FAIL illegal_dropped: err=%b busy=%b din=%b want 0 0 00", Err_illegal, Busy, Core_D_in);
        end
        A_valid = 1'b1; A_coin = 2'b00; B_valid = 1'b1; B_coin = 2'b11;
        tick;
        A_valid = 1'b0; B_valid = 1'b0;
        vecCount++;
        if (Err_illegal !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL dual_illegal: err=%b want 1", Err_illegal);
        end
        tick;
        vecCount++;
        if (Err_illegal !== 1'b0 || Busy !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL dual_single_pulse: err=%b busy=%b want 0 0", Err_illegal, Busy);
        end
    endtask

    task automatic test_reset_mid_gap;
        doReset;
        A_valid = 1'b1; A_coin = 2'b01; B_valid = 1'b1; B_coin = 2'b10;
        expQ.push_back(2'b01);
        tick;
        A_coin = 2'b10; B_valid = 1'b0;
        tick;
        A_valid = 1'b0;
        tick;
        expCoin = popExp();
        vecCount++;
        if (Core_D_in !== expCoin || Busy !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL midgap_issue: din=%b busy=%b want %b 1", Core_D_in, Busy, expCoin);
        end
        Reset = 1'b1;
        tick;
        Reset = 1'b0;
        expQ.delete();
        for (int i = 0; i < 5; i++) begin
            vecCount++;
            if (Core_D_in !== 2'b00 || Busy !== 1'b0 || A_ready !== 1'b1 || B_ready !== 1'b1) begin
                missCount++;
                $display("[TB] FAIL midgap_flush cyc%0d: din=%b busy=%b rdy=%b%b want 00 0 11", i, Core_D_in, Busy, A_ready, B_ready);
            end
            tick;
        end
    endtask

    task automatic test_back_to_back;
        int sent;
        int guard;
        doReset;
        sent = 0;
        guard = 0;
        while ((sent < 8 || expQ.size() != 0) && guard < 100) begin
            if (sent < 8) begin
                A_valid = 1'b1;
                A_coin = 2'($urandom_range(1, 2));
                if (A_ready) begin
                    expQ.push_back(A_coin);
                    sent++;
                end
            end else begin
                A_valid = 1'b0;
            end
            tick;
            guard++;
            if (Core_D_in !== 2'b00) begin
                expCoin = popExp();
                vecCount++;
                if (Core_D_in !== expCoin) begin
                    missCount++;
                    $display("[TB] FAIL b2b_order: din=%b want %b", Core_D_in, expCoin);
                end
            end
        end
        A_valid = 1'b0;
        vecCount++;
        if (expQ.size() != 0 || sent != 8) begin
            missCount++;
            $display("[TB] FAIL b2b_drain: left=%0d sent=%0d want 0 8", expQ.size(), sent);
        end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_round_robin;
        test_settle_full;
        test_events;
        test_illegal;
        test_reset_mid_gap;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
